cmd_scheduler: RTL and testbench

Frame scheduler feeding the command serializer at clk160. It shares the single 16-bit command frame slot between one trigger source and NREQ general requesters. Triggers take strict priority, and general requesters are arbitrated round-robin with packet locking. It guarantees a sync frame at least every SYNC_INTERVAL frames and fills idle slots with sync.

---
 rtl/cmd_scheduler.sv | 126 ++++++++++++
 tb/tb_cmd_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_scheduler.sv
// Command frame slot scheduler: strict-priority trigger, round-robin general
// requesters with packet locking, and sync insertion with a bounded interval.
module cmd_scheduler #(
   parameter int          NREQ          = 4,
   parameter int          SYNC_INTERVAL = 32,
   parameter logic [15:0] SYNC_WORD     = 16'h817E
) (
   input  logic                 rst,
   input  logic                 clk160,
   input  logic                 enable,
   input  logic                 trig_valid,
   input  logic [15:0]          trig_data,
   output logic                 trig_ready,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   output logic [15:0]          frame_out,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [7:0]           sync_count
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] SYNC_LAST = 8'(SYNC_INTERVAL - 1);

   typedef enum logic {
      ST_IDLE,
      ST_LOCK
   } arb_state_t;

   arb_state_t    state, state_nxt;
   logic [IW-1:0] lock_idx, lock_idx_nxt;
   logic [IW-1:0] rr_ptr, rr_ptr_nxt;
   logic [15:0]   frame_nxt;
   logic [7:0]    sync_count_nxt;
   logic          slot;
   logic          gen_found;
   logic [IW-1:0] gen_idx;
   logic [IW-1:0] cand;

   // Index arithmetic modulo NREQ, valid for non-power-of-two NREQ.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   assign slot = frame_valid & frame_ready;

   // Eligible general requester: the locked one, or the first valid from rr_ptr.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      gen_found = 1'b0;
      gen_idx   = '0;
      cand      = '0;
      if (state == ST_LOCK) begin
         gen_found = req_valid[lock_idx];
         gen_idx   = lock_idx;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!gen_found && req_valid[cand]) begin
               gen_found = 1'b1;
               gen_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      lock_idx_nxt   = lock_idx;
      rr_ptr_nxt     = rr_ptr;
      frame_nxt      = frame_out;
      sync_count_nxt = sync_count;
      trig_ready     = 1'b0;
      req_ready      = '0;
      if (slot) begin
         if (sync_count == SYNC_LAST) begin
            frame_nxt      = SYNC_WORD;
            sync_count_nxt = '0;
         end else if (trig_valid) begin
            frame_nxt      = trig_data;
            trig_ready     = 1'b1;
            sync_count_nxt = sync_count + 8'd1;
         end else if (enable && gen_found) begin
            frame_nxt          = req_data[int'(gen_idx)*16 +: 16];
            req_ready[gen_idx] = 1'b1;
            sync_count_nxt     = sync_count + 8'd1;
            if (req_last[gen_idx]) begin
               state_nxt  = ST_IDLE;
               rr_ptr_nxt = wrap_add(gen_idx, 1);
            end else begin
               state_nxt    = ST_LOCK;
               lock_idx_nxt = gen_idx;
            end
         end else begin
            // Idle slot (or disabled requesters): fill with sync, lock untouched.
            frame_nxt      = SYNC_WORD;
            sync_count_nxt = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk160 or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         lock_idx    <= '0;
         rr_ptr      <= '0;
         frame_out   <= SYNC_WORD;
         frame_valid <= 1'b0;
         sync_count  <= '0;
      end else begin
         state       <= state_nxt;
         lock_idx    <= lock_idx_nxt;
         rr_ptr      <= rr_ptr_nxt;
         frame_out   <= frame_nxt;
         frame_valid <= 1'b1;
         sync_count  <= sync_count_nxt;
      end
   end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed self-checking bench for cmd_scheduler (NREQ=4, SYNC_INTERVAL=32).
module tb_cmd_scheduler;

   localparam int          NREQ = 4;
   localparam logic [15:0] SYNC = 16'h817E;

   logic                 rst;
   logic                 clk160;
   logic                 enable;
   logic                 trig_valid;
   logic [15:0]          trig_data;
   logic                 trig_ready;
   logic [NREQ-1:0]      req_valid;
   logic [16*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      req_last;
   logic [NREQ-1:0]      req_ready;
   logic [15:0]          frame_out;
   logic                 frame_valid;
   logic                 frame_ready;
   logic [7:0]           sync_count;

   int n_checks = 0;
   int n_errors = 0;

   cmd_scheduler #(.NREQ(NREQ), .SYNC_INTERVAL(32), .SYNC_WORD(SYNC)) dut (
      .rst         (rst),
      .clk160      (clk160),
      .enable      (enable),
      .trig_valid  (trig_valid),
      .trig_data   (trig_data),
      .trig_ready  (trig_ready),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .frame_out   (frame_out),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .sync_count  (sync_count)
   );

   initial clk160 = 1'b0;
   always #3 clk160 = ~clk160;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One slot event followed by one cycle without frame_ready.
   task automatic do_slot(input string tag, input logic exp_trig,
                          input logic [NREQ-1:0] exp_req, input logic [15:0] exp_frame);
      @(negedge clk160);
      frame_ready = 1'b1;
      #1;
      check({tag, ".trig_ready"}, 32'(trig_ready), 32'(exp_trig));
      check({tag, ".req_ready"},  32'(req_ready),  32'(exp_req));
      @(posedge clk160);
      #1;
      frame_ready = 1'b0;
      check({tag, ".frame"}, 32'(frame_out), 32'(exp_frame));
      @(negedge clk160);
      check({tag, ".gap_ready"}, 32'({trig_ready, req_ready}), 32'd0);
   endtask

   task automatic set_req(input int i, input logic v, input logic [15:0] d, input logic l);
      req_valid[i]         = v;
      req_data[16*i +: 16] = d;
      req_last[i]          = l;
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b1;
      trig_valid  = 1'b0;
      trig_data   = '0;
      req_valid   = '0;
      req_data    = '0;
      req_last    = '0;
      frame_ready = 1'b0;

      // Reset: valid sources and frame_ready must not produce readies.
      repeat (2) @(posedge clk160);
      trig_valid  = 1'b1;
      req_valid   = '1;
      frame_ready = 1'b1;
      #1;
      check("rst.frame",       32'(frame_out),   32'(SYNC));
      check("rst.frame_valid", 32'(frame_valid), 32'd0);
      check("rst.sync_count",  32'(sync_count),  32'd0);
      check("rst.ready",       32'({trig_ready, req_ready}), 32'd0);
      @(negedge clk160);
      trig_valid  = 1'b0;
      req_valid   = '0;
      frame_ready = 1'b0;
      rst         = 1'b0;
      @(posedge clk160);
      #1;
      check("rel.frame_valid", 32'(frame_valid), 32'd1);
      check("rel.frame",       32'(frame_out),   32'(SYNC));

      // Idle: only syncs, counter stays at zero.
      for (int k = 0; k < 100; k++) begin
         do_slot("idle", 1'b0, 4'b0000, SYNC);
         check("idle.sync_count", 32'(sync_count), 32'd0);
      end

      // Sync enforcement: 31 triggers then a forced sync, repeated.
      trig_valid = 1'b1;
      trig_data  = 16'h2B2B;
      for (int k = 1; k <= 64; k++) begin
         if (k % 32 == 0) do_slot("force", 1'b0, 4'b0000, SYNC);
         else             do_slot("trig",  1'b1, 4'b0000, 16'h2B2B);
         check("trig.sync_count", 32'(sync_count), 32'(k % 32));
      end
      trig_valid = 1'b0;

      // Round-robin over four single-frame packets, rr_ptr wraps to 0.
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'hA0A0 + 16'(i), 1'b1);
      do_slot("rr0", 1'b0, 4'b0001, 16'hA0A0);
      do_slot("rr1", 1'b0, 4'b0010, 16'hA0A1);
      do_slot("rr2", 1'b0, 4'b0100, 16'hA0A2);
      do_slot("rr3", 1'b0, 4'b1000, 16'hA0A3);
      do_slot("rr4", 1'b0, 4'b0001, 16'hA0A0);
      check("rr.sync_count", 32'(sync_count), 32'd5);
      req_valid = '0;
      do_slot("rr.fill", 1'b0, 4'b0000, SYNC);

      // Packet lock on req 1 with a trigger inserted; req 2 waits.
      set_req(1, 1'b1, 16'h1A00, 1'b0);
      set_req(2, 1'b1, 16'h2222, 1'b1);
      do_slot("lock.1a", 1'b0, 4'b0010, 16'h1A00);
      set_req(1, 1'b1, 16'h1B00, 1'b0);
      trig_valid = 1'b1;
      trig_data  = 16'h7777;
      do_slot("lock.trig", 1'b1, 4'b0000, 16'h7777);
      trig_valid = 1'b0;
      do_slot("lock.1b", 1'b0, 4'b0010, 16'h1B00);
      set_req(1, 1'b1, 16'h1C00, 1'b1);
      do_slot("lock.1c", 1'b0, 4'b0010, 16'h1C00);
      req_valid[1] = 1'b0;
      do_slot("lock.2", 1'b0, 4'b0100, 16'h2222);
      req_valid = '0;
      do_slot("lock.fill", 1'b0, 4'b0000, SYNC);

      // Enable toggle in LOCK(0); rr_ptr is 3 so req 0 wins the search.
      set_req(0, 1'b1, 16'h0A00, 1'b0);
      set_req(1, 1'b1, 16'h1111, 1'b1);
      do_slot("en.0a", 1'b0, 4'b0001, 16'h0A00);
      set_req(0, 1'b1, 16'h0B00, 1'b0);
      enable = 1'b0;
      do_slot("en.off0", 1'b0, 4'b0000, SYNC);
      do_slot("en.off1", 1'b0, 4'b0000, SYNC);
      enable = 1'b1;
      do_slot("en.0b", 1'b0, 4'b0001, 16'h0B00);
      req_valid[0] = 1'b0;
      do_slot("en.hold", 1'b0, 4'b0000, SYNC);
      set_req(0, 1'b1, 16'h0C00, 1'b1);
      do_slot("en.0c", 1'b0, 4'b0001, 16'h0C00);
      req_valid[0] = 1'b0;
      do_slot("en.1", 1'b0, 4'b0010, 16'h1111);
      req_valid = '0;

      // Reset in LOCK(3); rr_ptr is 2 so req 3 is picked first.
      set_req(3, 1'b1, 16'h3A00, 1'b0);
      do_slot("mid.3a", 1'b0, 4'b1000, 16'h3A00);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'hA0A0 + 16'(i), 1'b1);
      frame_ready = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check("mid.frame",       32'(frame_out),   32'(SYNC));
      check("mid.frame_valid", 32'(frame_valid), 32'd0);
      check("mid.ready",       32'({trig_ready, req_ready}), 32'd0);
      @(posedge clk160);
      #1;
      check("mid.ready2",      32'({trig_ready, req_ready}), 32'd0);
      check("mid.sync_count",  32'(sync_count), 32'd0);
      @(negedge clk160);
      frame_ready = 1'b0;
      rst         = 1'b0;
      @(posedge clk160);
      #1;
      check("mid.rel_valid", 32'(frame_valid), 32'd1);
      do_slot("mid.rr0", 1'b0, 4'b0001, 16'hA0A0);
      do_slot("mid.rr1", 1'b0, 4'b0010, 16'hA0A1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
